// File: rtl/ds1302_pkg.sv
// ds1302_pkg: FSM state encoding, transaction kinds and DS1302 command constants.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ds1302_pkg;

  typedef enum logic [2:0] {
    IDLE, WP_OFF, WR_REG, WP_ON, RD_REG, RAM_WR, RAM_RD, ACK
  } state_t;

  typedef enum logic [2:0] {
    K_TIME_WR, K_TIME_RD, K_POLL, K_RAM_WR, K_RAM_RD, K_RAM_BAD
  } kind_t;

  localparam logic [7:0] CLK_BASE         = 8'h80;
  localparam logic [7:0] RAM_BASE         = 8'hC0;
  localparam logic [7:0] WP_ADDR          = 8'h8E;
  localparam logic [7:0] WP_OFF_DAT       = 8'h00;
  localparam logic [7:0] WP_ON_DAT        = 8'h80;
  localparam logic [7:0] ILLEGAL_RD       = 8'hFF;
  localparam logic [4:0] RAM_ILLEGAL_ADDR = 5'd31;

  // Command byte = base + 2*index, with bit 0 selecting read (1) or write (0).
  function automatic logic [7:0] cmd_byte(input logic [7:0] base, input logic [4:0] idx,
                                          input logic rd);
    return base + {2'b00, idx, rd};
  endfunction

endpackage

// File: rtl/ds1302_io.sv
// ds1302_io: bit-level DS1302 3-wire engine, one command+data frame per request, LSB first.
// Latency: 16 SCLK periods (32*HALF_CYC clk) from accepted command to a 1-cycle ack pulse.
// Backpressure: command held by requester until ack; a new frame starts only after the ack cycle.
module ds1302_io #(
  parameter int HALF_CYC = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_cmd_write,
  input  logic       i_cmd_read,
  input  logic [7:0] i_cmd_addr,
  input  logic [7:0] i_cmd_wdata,
  output logic       o_ack,
  output logic [7:0] o_rdata,
  output logic       o_ce,
  output logic       o_sclk,
  inout  wire        io_sio
);

  localparam int CW = (HALF_CYC > 1) ? $clog2(HALF_CYC) : 1;

  logic [CW-1:0] r_cnt;
  logic [3:0]    r_bit;
  logic          r_busy;
  logic          r_rd;
  logic          r_oe;
  logic [15:0]   r_shift;
  logic          w_start;
  logic          w_tick;

  // Holding off during the ack cycle keeps a still-asserted command from re-triggering.
  assign w_start = (i_cmd_write | i_cmd_read) & ~r_busy & ~o_ack;
  assign w_tick  = (r_cnt == CW'(HALF_CYC - 1));
  assign io_sio  = r_oe ? r_shift[0] : 1'bz;

  // Frame sequencer: bits change while SCLK is low, read bits are sampled just before each rise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt   <= '0;
      r_bit   <= '0;
      r_busy  <= 1'b0;
      r_rd    <= 1'b0;
      r_oe    <= 1'b0;
      r_shift <= '0;
      o_ack   <= 1'b0;
      o_rdata <= '0;
      o_ce    <= 1'b0;
      o_sclk  <= 1'b0;
    end else begin
      o_ack <= 1'b0;
      if (w_start) begin
        o_ce    <= 1'b1;
        o_sclk  <= 1'b0;
        r_busy  <= 1'b1;
        r_rd    <= i_cmd_read;
        r_oe    <= 1'b1;
        r_shift <= {i_cmd_wdata, i_cmd_addr};
        r_bit   <= '0;
        r_cnt   <= '0;
      end else if (r_busy) begin
        r_cnt <= w_tick ? '0 : r_cnt + 1'b1;
        if (w_tick) begin
          if (!o_sclk) begin
            o_sclk <= 1'b1;
            if (r_rd && r_bit[3]) o_rdata <= {io_sio, o_rdata[7:1]};
          end else begin
            o_sclk  <= 1'b0;
            r_shift <= {1'b0, r_shift[15:1]};
            r_bit   <= r_bit + 1'b1;
            // Device starts driving data on the falling edge after the 8th command bit.
            if (r_rd && r_bit == 4'd7) r_oe <= 1'b0;
            if (r_bit == 4'd15) begin
              o_ce   <= 1'b0;
              r_busy <= 1'b0;
              r_oe   <= 1'b0;
              o_ack  <= 1'b1;
            end
          end
        end
      end
    end
  end

endmodule

// File: rtl/ds1302_rtc_ctrl.sv
// ds1302_rtc_ctrl: DS1302 RTC controller (time burst, RAM byte, periodic poll); DS1302_WP_RESTORE_EN re-arms WP after writes.
// Latency: one ~32*HALF_CYC-cycle frame per register byte plus one ACK cycle; illegal RAM address acks after 1 cycle.
// Backpressure: level requests sampled only in IDLE; requester holds until its ack pulse.
module ds1302_rtc_ctrl
  import ds1302_pkg::*;
#(
  parameter int NUM_REGS    = 7,
  parameter int POLL_CYCLES = 50_000_000
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  ds1302_ce,
  output logic                  ds1302_sclk,
  inout  wire                   ds1302_io,
  input  logic                  time_wr_req,
  input  logic                  time_rd_req,
  output logic                  time_ack,
  input  logic [8*NUM_REGS-1:0] time_wdata,
  output logic [8*NUM_REGS-1:0] time_rdata,
  input  logic                  ram_req,
  input  logic                  ram_we,
  input  logic [4:0]            ram_addr,
  input  logic [7:0]            ram_wdata,
  output logic [7:0]            ram_rdata,
  output logic                  ram_ack,
  input  logic                  poll_en,
  output logic                  rd_valid,
  output logic                  busy
);

`ifdef DS1302_WP_RESTORE_EN
  localparam state_t AFTER_WR = WP_ON;
`else
  localparam state_t AFTER_WR = ACK;
`endif

  state_t                r_state, w_state_nxt;
  kind_t                 r_kind, w_kind_nxt;
  logic [2:0]            r_idx;
  logic [4:0]            r_addr;
  logic [8*NUM_REGS-1:0] r_shadow, w_shadow_nxt;
  logic [31:0]           r_poll_cnt;
  logic                  r_poll_pend;
  logic                  w_cmd_write, w_cmd_read, w_eng_ack, w_last, w_rd_start;
  logic [7:0]            w_cmd_addr, w_cmd_wdata, w_eng_rdata;

  assign w_last     = (r_idx == 3'(NUM_REGS - 1));
  assign w_rd_start = (r_state == IDLE) && (w_state_nxt == RD_REG);
  assign busy       = (r_state != IDLE);
  assign time_ack   = (r_state == ACK) && (r_kind == K_TIME_WR || r_kind == K_TIME_RD);
  assign rd_valid   = (r_state == ACK) && (r_kind == K_TIME_RD || r_kind == K_POLL);
  assign ram_ack    = (r_state == ACK) &&
                      (r_kind == K_RAM_WR || r_kind == K_RAM_RD || r_kind == K_RAM_BAD);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next state and engine command; each command stays up until the engine acks it.
  always_comb begin
    w_state_nxt = r_state;
    w_kind_nxt  = r_kind;
    w_cmd_write = 1'b0;
    w_cmd_read  = 1'b0;
    w_cmd_addr  = WP_ADDR;
    w_cmd_wdata = WP_OFF_DAT;
    unique case (r_state)
      IDLE: begin
        if (time_wr_req) begin
          w_kind_nxt  = K_TIME_WR;
          w_state_nxt = WP_OFF;
        end else if (ram_req) begin
          if (ram_addr == RAM_ILLEGAL_ADDR) begin
            w_kind_nxt  = K_RAM_BAD;
            w_state_nxt = ACK;
          end else if (ram_we) begin
            w_kind_nxt  = K_RAM_WR;
            w_state_nxt = WP_OFF;
          end else begin
            w_kind_nxt  = K_RAM_RD;
            w_state_nxt = RAM_RD;
          end
        end else if (time_rd_req) begin
          w_kind_nxt  = K_TIME_RD;
          w_state_nxt = RD_REG;
        end else if (r_poll_pend) begin
          w_kind_nxt  = K_POLL;
          w_state_nxt = RD_REG;
        end
      end
      WP_OFF: begin
        w_cmd_write = 1'b1;
        if (w_eng_ack) w_state_nxt = (r_kind == K_TIME_WR) ? WR_REG : RAM_WR;
      end
      WR_REG: begin
        w_cmd_write = 1'b1;
        w_cmd_addr  = cmd_byte(CLK_BASE, {2'b00, r_idx}, 1'b0);
        w_cmd_wdata = time_wdata[{r_idx, 3'b000} +: 8];
        if (w_eng_ack && w_last) w_state_nxt = AFTER_WR;
      end
      WP_ON: begin
        w_cmd_write = 1'b1;
        w_cmd_wdata = WP_ON_DAT;
        if (w_eng_ack) w_state_nxt = ACK;
      end
      RD_REG: begin
        w_cmd_read = 1'b1;
        w_cmd_addr = cmd_byte(CLK_BASE, {2'b00, r_idx}, 1'b1);
        if (w_eng_ack && w_last) w_state_nxt = ACK;
      end
      RAM_WR: begin
        w_cmd_write = 1'b1;
        w_cmd_addr  = cmd_byte(RAM_BASE, r_addr, 1'b0);
        w_cmd_wdata = ram_wdata;
        if (w_eng_ack) w_state_nxt = AFTER_WR;
      end
      RAM_RD: begin
        w_cmd_read = 1'b1;
        w_cmd_addr = cmd_byte(RAM_BASE, r_addr, 1'b1);
        if (w_eng_ack) w_state_nxt = ACK;
      end
      ACK:     w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Shadow image with the byte just read merged in at the current index.
  always_comb begin
    w_shadow_nxt = r_shadow;
    w_shadow_nxt[{r_idx, 3'b000} +: 8] = w_eng_rdata;
  end

  // Datapath: register index, RAM address, read shadow and the published read results.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_kind     <= K_TIME_WR;
      r_idx      <= '0;
      r_addr     <= '0;
      r_shadow   <= '0;
      time_rdata <= '0;
      ram_rdata  <= '0;
    end else begin
      r_kind <= w_kind_nxt;
      if (r_state == IDLE) begin
        r_idx  <= '0;
        r_addr <= ram_addr;
        // The only direct IDLE->ACK path is the illegal RAM address.
        if (w_state_nxt == ACK) ram_rdata <= ILLEGAL_RD;
      end
      if (w_eng_ack && (r_state == WR_REG || r_state == RD_REG)) r_idx <= r_idx + 1'b1;
      if (w_eng_ack && r_state == RD_REG) begin
        r_shadow <= w_shadow_nxt;
        if (w_last) time_rdata <= w_shadow_nxt;
      end
      if (w_eng_ack && r_state == RAM_RD) ram_rdata <= w_eng_rdata;
    end
  end

  // Poll timer: wraps every POLL_CYCLES; wraps during a busy period merge into one pending poll.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_poll_cnt  <= '0;
      r_poll_pend <= 1'b0;
    end else if (!poll_en || POLL_CYCLES == 0) begin
      r_poll_cnt  <= '0;
      r_poll_pend <= 1'b0;
    end else begin
      if (w_rd_start) r_poll_pend <= 1'b0;
      if (r_poll_cnt == 32'(POLL_CYCLES - 1)) begin
        r_poll_cnt  <= '0;
        r_poll_pend <= 1'b1;
      end else begin
        r_poll_cnt <= r_poll_cnt + 1'b1;
      end
    end
  end

  ds1302_io u_io (
    .clk         (clk),
    .rst         (rst),
    .i_cmd_write (w_cmd_write),
    .i_cmd_read  (w_cmd_read),
    .i_cmd_addr  (w_cmd_addr),
    .i_cmd_wdata (w_cmd_wdata),
    .o_ack       (w_eng_ack),
    .o_rdata     (w_eng_rdata),
    .o_ce        (ds1302_ce),
    .o_sclk      (ds1302_sclk),
    .io_sio      (ds1302_io)
  );

endmodule

// File: doc/ds1302_rtc_ctrl.md
DS1302_RTC_CTRL -- requirements
Module: ds1302_rtc_ctrl

Interface
REQ-001 SHALL have parameter NUM_REGS, default 7: number of consecutive clock registers accessed; legal range 1..8.
REQ-002 SHALL have parameter POLL_CYCLES, default 50_000_000: auto-read interval in clk cycles; 0 disables auto-read.
REQ-003 SHALL have port clk, in, 1: clock; already decided.
REQ-004 SHALL have port rst, in, 1: reset, asynchronous, active-high; already decided.
REQ-005 SHALL have ports ds1302_ce out 1, ds1302_sclk out 1, ds1302_io inout 1: DS1302 3-wire bus.
REQ-006 SHALL have ports time_wr_req in 1, time_rd_req in 1, time_ack out 1: time request/acknowledge.
REQ-007 SHALL have ports time_wdata in 8*NUM_REGS and time_rdata out 8*NUM_REGS: register i occupies bits [8i+7:8i], order sec, min, hour, date, month, week, year, ctrl.
REQ-008 SHALL have ports ram_req in 1, ram_we in 1, ram_addr in 5, ram_wdata in 8, ram_rdata out 8, ram_ack out 1: single-byte RAM access.
REQ-009 SHALL have ports poll_en in 1, rd_valid out 1, busy out 1: auto-read enable, new-snapshot pulse, and transaction-in-progress flag.

Function
REQ-010 SHALL sample requests only in IDLE, with priority time_wr_req > ram_req > time_rd_req > pending poll.
REQ-011 SHALL hold requests as level signals; the requester keeps a request high until its ack, and a request still high one cycle after its ack starts a new transaction.
REQ-012 SHALL use FSM states IDLE, WP_OFF, WR_REG, WP_ON, RD_REG, RAM_WR, RAM_RD, ACK.
REQ-013 SHALL run time write as IDLE -> WP_OFF -> WR_REG (i = 0..NUM_REGS-1) -> [WP_ON] -> ACK -> IDLE.
REQ-014 SHALL run time read and poll as IDLE -> RD_REG (i = 0..NUM_REGS-1) -> ACK -> IDLE.
REQ-015 SHALL run RAM access as IDLE -> WP_OFF -> RAM_WR -> [WP_ON] -> ACK when ram_we=1, else IDLE -> RAM_RD -> ACK.
REQ-016 SHALL use command bytes: write 0x80+2i; read 0x81+2i; WP register 0x8E with data 0x00 (off) or 0x80 (on); RAM write 0xC0+2*ram_addr; RAM read 0xC1+2*ram_addr.
REQ-017 SHALL assert the engine's cmd_write/cmd_read from state entry until its ack pulse, and advance state on that ack only.
REQ-018 SHALL latch input data (time_wdata byte i, ram_wdata) when each command is issued, not at request time.
REQ-019 SHALL collect read bytes in a shadow register and update time_rdata for all NUM_REGS bytes in the same cycle, on entry to ACK.
REQ-020 SHALL pulse rd_valid for 1 cycle at that update, including for poll-initiated reads.
REQ-021 SHALL pulse time_ack for 1 cycle in ACK for time transactions only, and shall not pulse it for a poll.
REQ-022 SHALL pulse ram_ack for 1 cycle in ACK for RAM transactions only, and shall load ram_rdata on RAM_RD completion.
REQ-023 SHALL treat ram_addr=31 as illegal: no bus transaction, ram_rdata=0xFF, ram_ack 1 cycle after sampling.
REQ-024 SHALL run the poll counter while poll_en=1 and POLL_CYCLES!=0, counting 0..POLL_CYCLES-1 and wrapping; at wrap it sets poll_pending.
REQ-025 SHALL clear poll_pending when a read sequence starts; several wraps while busy collapse into one pending poll.
REQ-026 SHALL clear the poll counter and poll_pending when poll_en=0.
REQ-027 SHALL drive busy=1 in every state except IDLE.

Reset
REQ-028 SHALL, on rst, force state IDLE, all outputs to 0 (time_rdata, ram_rdata, acks, rd_valid, busy), the poll counter to 0, poll_pending to 0, and ds1302_ce low via the engine.
REQ-029 SHALL abort any transaction on rst mid-operation with no ack and no partial time_rdata update.

Configuration
REQ-030 SHALL, with macro DS1302_WP_RESTORE_EN defined, enter WP_ON after every write (writing 0x8E=0x80) before ACK.
REQ-031 SHALL, without DS1302_WP_RESTORE_EN, leave WP cleared after writes and make WP_ON unreachable, going straight to ACK.

Structure
REQ-032 SHALL take the FSM state enum and constants (0x80 clock base, 0xC0 RAM base, 0x8E WP address, 0x00/0x80 WP data, 0xFF illegal-read value) from shared package ds1302_pkg.
REQ-033 SHALL instantiate exactly one sub-module, existing serial engine ds1302_io, for bit-level bus timing.

Verification
REQ-034 SHALL cover: time_wr_req with NUM_REGS=7 and time_wdata=0x24_06_03_15_59_30_45 -> bus bytes 8E/00, 80/45, 82/30, 84/59, 86/15, 88/03, 8A/06, 8C/24, (8E/80 if _EN) -> one time_ack.
REQ-035 SHALL cover: model returns sec=0x12, min=0x34, time_rd_req -> time_rdata bytes change in one cycle, rd_valid and time_ack pulse together.
REQ-036 SHALL cover: POLL_CYCLES=1000 with poll_en=1 -> reads start every 1000 cycles (first after counter wrap), rd_valid pulses, time_ack stays 0.
REQ-037 SHALL cover: ram_req with ram_we=1, addr=5, data=0xA5, then ram_we=0, addr=5 -> bytes CA/A5 then CB, ram_rdata=0xA5; addr=31 -> 0xFF, no ce activity.
REQ-038 SHALL cover: time_wr_req and time_rd_req asserted the same cycle -> write completes first; rst asserted during RD_REG i=3 -> ce low, time_rdata stays 0, no ack.
